lsu_stage: RTL and testbench
============================

# lsu_stage

Parametrised successor to the memory-access pipeline stage for FRI-V.
- Registers the execute-stage result.
- Drives a data-memory request/acknowledge bus with byte lanes.
- Formats load data with sign/zero extension.
- Raises misalignment and bus-timeout exceptions.
- Presents one result per instruction to writeback.

It sits between execute and writeback. It asserts `o_busy` while a memory transaction is outstanding so the hazard unit stalls upstream.

## Interface
- `DATA_W`, default 32: data/register width; legal values are 32 or 64 (64 enables `ld`/`lwu`/`sd`).
- `ADDR_W`, default 32: address width.
- `TIMEOUT`, default 255: cycles to wait for `i_mem_ack` before an access fault; 0 disables the timeout.
- `i_clk`, in, 1: clock; single clock domain.
- `i_rst`, in, 1: reset; asynchronous, active-high.
- `i_flush`, in, 1: kill the held instruction.
- `i_stall`, in, 1: downstream stall; hold capture and outputs.
- `i_valid`, in, 1: execute result valid.
- `i_memop`, in, 4: memory operation encoding:
  - nop=0, lb=1, lh=2, lw=3, lbu=4, lhu=5, sb=6, sh=7, sw=8.
  - ld=9, lwu=10, sd=11 (64-bit only).
- `i_rd`, in, 5: destination register.
- `i_pc`, in, ADDR_W: instruction PC.
- `i_alu_data`, in, DATA_W: ALU result / effective address.
- `i_store_data`, in, DATA_W: store operand.
- `o_mem_req`, out, 1: bus request.
- `o_mem_we`, out, 1: write.
- `o_mem_addr`, out, ADDR_W: address aligned to DATA_W/8.
- `o_mem_be`, out, DATA_W/8: byte enables.
- `o_mem_wdata`, out, DATA_W: lane-replicated store data.
- `i_mem_ack`, in, 1: transaction complete.
- `i_mem_rdata`, in, DATA_W: read data, valid with ack.
- `o_busy`, out, 1: transaction outstanding; upstream must hold its inputs.
- `o_valid`, `o_rd`, `o_pc`, `o_result` (DATA_W): writeback result.
- `o_exc`, out, 1: exception flag.
- `o_exc_cause`, out, 4: exception cause:
  - 4 = load misaligned, 5 = load fault.
  - 6 = store misaligned, 7 = store fault.

## Operation
- **States:** IDLE, WAIT, DONE.
- **Capture:** inputs are registered when `!i_stall && state!=WAIT`. The valid bit is cleared instead of loaded when `i_flush`.
- **Non-memory instruction** (memop=0), or invalid: state goes to IDLE. Outputs come straight from the stage registers; `o_result` = ALU data.
- **Valid, aligned memory op:** state goes to WAIT.
  - `o_mem_req`=1 and the bus outputs are held stable until `i_mem_ack`.
  - On ack, state goes to DONE and the result register loads the formatted read data (loads) or ALU data (stores).
- **Load formatting:** the lane is selected by the low address bits. lb/lh/lw sign-extend to DATA_W; lbu/lhu/lwu zero-extend.
- **Store formatting:** the byte/half/word is replicated across all lanes. `o_mem_be` = size mask shifted left by the byte offset.
- **Timeout:** a counter runs in WAIT. When it reaches TIMEOUT without ack, state goes to DONE with `o_exc`=1 and cause 5 or 7. The counter clears on entry to WAIT.
- **Flush during WAIT:** the bus transaction continues until ack or timeout, with the request held. The result is discarded (valid already 0) and no exception is reported.
- **Outputs:**
  - `o_valid` = valid bit && state!=WAIT.
  - `o_busy` = (state==WAIT).
  - `o_exc` is qualified by `o_valid`.
- **Reset values:** state IDLE, valid 0, counter 0. All outputs 0, including `o_mem_req`, `o_valid`, `o_exc`, `o_busy` and the data outputs.

## Timing
- Non-memory op: result on the outputs 1 cycle after capture.
- Memory op: request asserted 1 cycle after capture. Result valid 1 cycle after the `i_mem_ack` cycle; minimum latency is 2 cycles for zero-wait memory.
- Back-to-back: in DONE, a new capture (when not stalled) occurs in the same cycle the result is presented.
- `i_stall` in IDLE/DONE holds all outputs unchanged.
- `i_stall` does not stop an outstanding request.
- Flush and stall asserted together: flush wins for the valid bit.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned valid load/store (half on an odd address; word/double not size-aligned) issues no request and stays IDLE.
  - Outputs next cycle are `o_valid`=1, `o_exc`=1, cause 4 or 6, and `o_result` = faulting address.
- Undefined: the low address bits below the access size are ignored. The access is forced aligned and no exception is raised.

## Test plan
- **lb with sign extension:** DATA_W=32, lb at 0x1003, ack after 2 cycles with rdata 0x80AABBCC -> `o_mem_be`=0x8 during request; result 0xFFFFFF80 valid 1 cycle after ack.
- **sh lane placement:** sh of 0x1234 at 0x2002 -> `o_mem_we`=1, be=0xC, wdata=0x12341234, addr 0x2000.
- **Timeout:** TIMEOUT=4 and ack never arrives -> after 4 WAIT cycles, `o_exc`=1, cause 5, `o_valid`=1, `o_busy` falls.
- **Flush mid-transaction:** flush asserted in WAIT, ack 3 cycles later -> request held until ack, then `o_valid`=0 and no exception.
- **Misalignment:** with `LSU_MISALIGN_TRAP_EN`, lw at 0x1002 -> no `o_mem_req`, cause 4, result 0x1002. Without the macro -> request at 0x1000 with be=0xF.
- **Async reset:** `i_rst` mid-WAIT -> `o_mem_req`, `o_busy` and `o_valid` go to 0 immediately, without a clock edge.

Source files
------------

// File: rtl/lsu_stage_if.sv
// lsu_stage_if: data-memory request/acknowledge bus with per-byte lane enables.
// The master drives the request; the slave answers with ack and read data.
interface lsu_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     wdata;
    logic                  ack;
    logic [DATA_W-1:0]     rdata;
    modport master(output req, we, addr, be, wdata, input ack, rdata);
    modport slave(input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/lsu_stage.sv
// lsu_stage: FRI-V memory-access stage with lane formatting, bus timeout and one result per instruction.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses; otherwise they are forced aligned.
module lsu_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_stall,
    input  logic              i_valid,
    input  logic [3:0]        i_memop,
    input  logic [4:0]        i_rd,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [DATA_W-1:0] i_alu_data,
    input  logic [DATA_W-1:0] i_store_data,
    lsu_stage_if.master       mem,
    output logic              o_busy,
    output logic              o_valid,
    output logic [4:0]        o_rd,
    output logic [ADDR_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_result,
    output logic              o_exc,
    output logic [3:0]        o_exc_cause
);
    localparam int NB = DATA_W / 8;
    localparam int OW = $clog2(NB);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t state, state_n;

    function automatic logic [1:0] op_size(input logic [3:0] op);
        return (op == 4'd1 || op == 4'd4 || op == 4'd6) ? 2'd0 :
               (op == 4'd2 || op == 4'd5 || op == 4'd7) ? 2'd1 :
               (op == 4'd9 || op == 4'd11) ? 2'd3 : 2'd2;
    endfunction

    function automatic logic is_mem(input logic [3:0] op);
        return (op inside {[4'd1:4'd8]}) || (DATA_W == 64 && (op inside {[4'd9:4'd11]}));
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return op inside {4'd6, 4'd7, 4'd8, 4'd11};
    endfunction

    function automatic logic [OW-1:0] low_mask(input logic [1:0] sz);
        return OW'((1 << sz) - 1);
    endfunction

    logic              v_q, exc_q;
    logic [3:0]        op_q, cause_q;
    logic [4:0]        rd_q;
    logic [ADDR_W-1:0] pc_q, ea;
    logic [DATA_W-1:0] alu_q, sd_q, res_q, lane, ld_data;
    logic [CW-1:0]     cnt;
    logic              cap, in_trap, go, to_hit;
    logic [1:0]        sz;
    logic [OW-1:0]     off;
    logic [NB-1:0]     smask;

    always_comb begin
        cap = !i_stall && state != WAIT;
`ifdef LSU_MISALIGN_TRAP_EN
        in_trap = i_valid && !i_flush && is_mem(i_memop) &&
                  |(i_alu_data[OW-1:0] & low_mask(op_size(i_memop)));
`else
        in_trap = 1'b0;
`endif
        go = i_valid && !i_flush && is_mem(i_memop) && !in_trap;
        to_hit = TIMEOUT != 0 && cnt == LAST && !mem.ack;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else state <= state_n;
    end

    always_comb
        state_n = state == WAIT ? ((mem.ack || to_hit) ? DONE : WAIT) :
                  cap ? (go ? WAIT : IDLE) : state;

    // The valid bit obeys flush in every state, so a killed WAIT still finishes its bus cycle silently
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v_q     <= 1'b0;
            exc_q   <= 1'b0;
            op_q    <= '0;
            cause_q <= '0;
            rd_q    <= '0;
            pc_q    <= '0;
            alu_q   <= '0;
            sd_q    <= '0;
            res_q   <= '0;
            cnt     <= '0;
        end else begin
            if (i_flush) v_q <= 1'b0;
            else if (cap) v_q <= i_valid;
            if (state == WAIT) begin
                cnt <= cnt + CW'(1);
                if (mem.ack) res_q <= is_store(op_q) ? alu_q : ld_data;
                else if (to_hit) begin
                    exc_q   <= 1'b1;
                    cause_q <= is_store(op_q) ? 4'd7 : 4'd5;
                end
            end else if (cap) begin
                op_q    <= i_memop;
                rd_q    <= i_rd;
                pc_q    <= i_pc;
                alu_q   <= i_alu_data;
                sd_q    <= i_store_data;
                res_q   <= i_alu_data;
                exc_q   <= in_trap;
                cause_q <= is_store(i_memop) ? 4'd6 : 4'd4;
                cnt     <= '0;
            end
        end
    end

    always_comb begin
        sz = op_size(op_q);
        off = alu_q[OW-1:0] & ~low_mask(sz);
        smask = NB'((1 << (1 << sz)) - 1);
        ea = ADDR_W'(alu_q);
        lane = mem.rdata >> {off, 3'b000};
        ld_data = op_q == 4'd1  ? DATA_W'($signed(lane[7:0])) :
                  op_q == 4'd2  ? DATA_W'($signed(lane[15:0])) :
                  op_q == 4'd3  ? DATA_W'($signed(lane[31:0])) :
                  op_q == 4'd4  ? DATA_W'(lane[7:0]) :
                  op_q == 4'd5  ? DATA_W'(lane[15:0]) :
                  op_q == 4'd10 ? DATA_W'(lane[31:0]) : lane;
        mem.req = state == WAIT;
        mem.we = state == WAIT && is_store(op_q);
        mem.addr = {ea[ADDR_W-1:OW], OW'(0)};
        mem.be = state == WAIT ? smask << off : '0;
        mem.wdata = sz == 2'd0 ? {NB{sd_q[7:0]}} :
                    sz == 2'd1 ? {(NB/2){sd_q[15:0]}} :
                    sz == 2'd2 ? {(NB/4){sd_q[31:0]}} : sd_q;
        o_busy = state == WAIT;
        o_valid = v_q && state != WAIT;
        o_rd = rd_q;
        o_pc = pc_q;
        o_result = res_q;
        o_exc = v_q && state != WAIT && exc_q;
        o_exc_cause = (v_q && state != WAIT && exc_q) ? cause_q : 4'd0;
    end
endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: directed checks of lsu_stage (DATA_W=32, TIMEOUT=4) with hand-computed expectations.
module tb_lsu_stage;
    logic        i_clk = 1'b0, i_rst = 1'b1, i_flush = 1'b0, i_stall = 1'b0, i_valid = 1'b0;
    logic [3:0]  i_memop = '0;
    logic [4:0]  i_rd = '0;
    logic [31:0] i_pc = '0, i_alu_data = '0, i_store_data = '0;
    logic        o_busy, o_valid, o_exc;
    logic [4:0]  o_rd;
    logic [31:0] o_pc, o_result;
    logic [3:0]  o_exc_cause;
    int checks = 0, failures = 0;

    lsu_stage_if #(.DATA_W(32), .ADDR_W(32)) bus();

    lsu_stage #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_stall(i_stall),
        .i_valid(i_valid), .i_memop(i_memop), .i_rd(i_rd), .i_pc(i_pc),
        .i_alu_data(i_alu_data), .i_store_data(i_store_data), .mem(bus),
        .o_busy(o_busy), .o_valid(o_valid), .o_rd(o_rd), .o_pc(o_pc),
        .o_result(o_result), .o_exc(o_exc), .o_exc_cause(o_exc_cause)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata);
        i_valid = 1'b1;
        i_memop = op;
        i_alu_data = addr;
        i_store_data = sdata;
        tick;
        i_valid = 1'b0;
        i_memop = '0;
    endtask

    task automatic run_mem(input string tag, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [31:0] rdata, input int gap,
                           input logic [3:0] exp_be, input logic [31:0] exp_addr,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_res);
        issue(op, addr, sdata);
        check({tag, "_req"}, bus.req, 1'b1);
        check({tag, "_busy"}, o_busy, 1'b1);
        check({tag, "_be"}, bus.be, exp_be);
        check({tag, "_addr"}, bus.addr, exp_addr);
        check({tag, "_we"}, bus.we, op inside {4'd6, 4'd7, 4'd8});
        if (op inside {4'd6, 4'd7, 4'd8}) check({tag, "_wdata"}, bus.wdata, exp_wdata);
        repeat (gap) tick;
        bus.ack = 1'b1;
        bus.rdata = rdata;
        tick;
        bus.ack = 1'b0;
        check({tag, "_valid"}, o_valid, 1'b1);
        check({tag, "_res"}, o_result, exp_res);
        check({tag, "_exc"}, o_exc, 1'b0);
        check({tag, "_idle"}, bus.req, 1'b0);
    endtask

    task automatic run_timeout(input string tag, input logic [3:0] op, input logic [31:0] addr,
                               input logic [3:0] exp_cause);
        issue(op, addr, 32'h0);
        repeat (3) tick;
        check({tag, "_busy3"}, o_busy, 1'b1);
        check({tag, "_valid3"}, o_valid, 1'b0);
        tick;
        check({tag, "_busy"}, o_busy, 1'b0);
        check({tag, "_valid"}, o_valid, 1'b1);
        check({tag, "_exc"}, o_exc, 1'b1);
        check({tag, "_cause"}, o_exc_cause, exp_cause);
    endtask

    initial begin
        bus.ack = 1'b0;
        bus.rdata = '0;
        #1;
        check("rst_valid", o_valid, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_req", bus.req, 1'b0);
        check("rst_be", bus.be, 4'h0);
        check("rst_exc", o_exc, 1'b0);
        check("rst_res", o_result, 32'h0);
        tick;
        tick;
        i_rst = 1'b0;
        i_rd = 5'd5;
        i_pc = 32'h100;
        issue(4'd0, 32'hDEADBEEF, 32'h0);
        check("alu_valid", o_valid, 1'b1);
        check("alu_res", o_result, 32'hDEADBEEF);
        check("alu_rd", o_rd, 5'd5);
        check("alu_pc", o_pc, 32'h100);
        check("alu_req", bus.req, 1'b0);
        i_stall = 1'b1;
        i_valid = 1'b1;
        i_alu_data = 32'h55;
        tick;
        check("stall_valid", o_valid, 1'b1);
        check("stall_res", o_result, 32'hDEADBEEF);
        i_flush = 1'b1;
        tick;
        check("stall_flush_valid", o_valid, 1'b0);
        i_flush = 1'b0;
        i_stall = 1'b0;
        i_valid = 1'b0;
        tick;
        i_rd = 5'd7;
        run_mem("lb", 4'd1, 32'h1003, 32'h0, 32'h80AABBCC, 1, 4'h8, 32'h1000, 32'h0, 32'hFFFFFF80);
        run_mem("lbu", 4'd4, 32'h1001, 32'h0, 32'h1234F5AB, 0, 4'h2, 32'h1000, 32'h0, 32'h000000F5);
        run_mem("lh", 4'd2, 32'h3002, 32'h0, 32'h8001BEEF, 0, 4'hC, 32'h3000, 32'h0, 32'hFFFF8001);
        run_mem("lhu", 4'd5, 32'h3000, 32'h0, 32'h8001BEEF, 2, 4'h3, 32'h3000, 32'h0, 32'h0000BEEF);
        run_mem("lw", 4'd3, 32'h4004, 32'h0, 32'h89ABCDEF, 0, 4'hF, 32'h4004, 32'h0, 32'h89ABCDEF);
        run_mem("sh", 4'd7, 32'h2002, 32'hABCD1234, 32'h0, 0, 4'hC, 32'h2000, 32'h12341234, 32'h2002);
        run_mem("sb", 4'd6, 32'h5001, 32'h000000A5, 32'h0, 1, 4'h2, 32'h5000, 32'hA5A5A5A5, 32'h5001);
        run_mem("sw", 4'd8, 32'h6000, 32'hCAFEF00D, 32'h0, 0, 4'hF, 32'h6000, 32'hCAFEF00D, 32'h6000);
`ifdef LSU_MISALIGN_TRAP_EN
        issue(4'd3, 32'h1002, 32'h0);
        check("mis_req", bus.req, 1'b0);
        check("mis_valid", o_valid, 1'b1);
        check("mis_exc", o_exc, 1'b1);
        check("mis_cause", o_exc_cause, 4'd4);
        check("mis_res", o_result, 32'h1002);
        issue(4'd7, 32'h2001, 32'h0);
        check("mis_st_cause", o_exc_cause, 4'd6);
`else
        run_mem("mis", 4'd3, 32'h1002, 32'h0, 32'h11223344, 0, 4'hF, 32'h1000, 32'h0, 32'h11223344);
`endif
        run_timeout("to_ld", 4'd3, 32'h7000, 4'd5);
        run_timeout("to_st", 4'd8, 32'h7004, 4'd7);
        issue(4'd3, 32'h8000, 32'h0);
        i_flush = 1'b1;
        tick;
        i_flush = 1'b0;
        check("fl_req1", bus.req, 1'b1);
        tick;
        check("fl_req2", bus.req, 1'b1);
        bus.ack = 1'b1;
        bus.rdata = 32'h12345678;
        tick;
        bus.ack = 1'b0;
        check("fl_valid", o_valid, 1'b0);
        check("fl_exc", o_exc, 1'b0);
        check("fl_busy", o_busy, 1'b0);
        check("fl_req", bus.req, 1'b0);
        issue(4'd3, 32'h9000, 32'h0);
        check("ar_req_pre", bus.req, 1'b1);
        #2;
        i_rst = 1'b1;
        #1;
        check("ar_req", bus.req, 1'b0);
        check("ar_busy", o_busy, 1'b0);
        check("ar_valid", o_valid, 1'b0);
        tick;
        i_rst = 1'b0;
        tick;
        check("ar_idle", o_busy, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
